seg7_scan_capture: RTL

//  Receive-side counterpart of the team's BCD-to-7-segment decoder. It watches a

---
 rtl/seg7_scan_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// Purpose : recovers BCD digits from a multiplexed 7-segment bus (seg + one-hot dig)
//           by synchronizing, waiting for each digit to hold steady, decoding it, and
//           assembling complete NDIG-digit frames.
// Latency : 2-flop synchronizer + STABLE_CYCLES identical samples per digit to capture;
//           frame published one edge after the last missing digit is captured.
// Backpressure: none; the bus is observed passively and frames overwrite the outputs.
// Ports   : clk, rst (async, active-high); seg[6:0] (a..g), dig[NDIG-1:0] (one-hot
//           enables); clr (sync clear of assembly); digits, digit_err, frame_valid,
//           frame_done (1-cycle publish pulse).
module seg7_scan_capture #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig,
    input  logic                clr,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_valid,
    output logic                frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_HUNT, S_COUNT, S_HOLD} state_t;

    // synchronizer stages
    logic [6:0]            seg_m, s_seg;
    logic [NDIG-1:0]       dig_m, s_dig;

    // tracker
    state_t                state;
    logic [6:0]            l_seg;
    logic [NDIG-1:0]       l_dig;
    logic [CW-1:0]         cnt;

    // frame assembly
    logic [NDIG-1:0][3:0]  stage_dig;
    logic [NDIG-1:0]       stage_err;
    logic [NDIG-1:0]       seen;

    function automatic logic is_onehot(input logic [NDIG-1:0] v);
        return (v != '0) && ((v & (v - NDIG'(1))) == '0);
    endfunction

    function automatic logic [IW-1:0] onehot_idx(input logic [NDIG-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i]) r = r | IW'(i);
        end
        return r;
    endfunction

    // returns {error, code}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = {1'b0, 4'h0};
            7'b0110000: r = {1'b0, 4'h1};
            7'b1101101: r = {1'b0, 4'h2};
            7'b1111001: r = {1'b0, 4'h3};
            7'b0110011: r = {1'b0, 4'h4};
            7'b1011011: r = {1'b0, 4'h5};
            7'b1011111: r = {1'b0, 4'h6};
            7'b1110000: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1111011: r = {1'b0, 4'h9};
            7'b0000000: r = {1'b0, 4'hA};   // blanked digit
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    logic              sample_eq;
    logic              s_onehot;
    logic              capture;
    logic              publish;
    logic [IW-1:0]     cap_idx;
    logic [NDIG-1:0]   cap_mask;
    logic [4:0]        cap_dec;

    always_comb begin
        sample_eq = (s_seg == l_seg) && (s_dig == l_dig);
        s_onehot  = is_onehot(s_dig);
        // the sample counted this edge is the STABLE_CYCLES-th identical one
        capture   = (state == S_COUNT) && sample_eq && (cnt == CW'(STABLE_CYCLES - 1));
        // publish one edge after seen fills up
        publish   = &seen;
        cap_idx   = onehot_idx(l_dig);
        cap_mask  = NDIG'(1) << cap_idx;
        cap_dec   = decode(l_seg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m       <= '0;
            s_seg       <= '0;
            dig_m       <= '0;
            s_dig       <= '0;
            state       <= S_HUNT;
            l_seg       <= '0;
            l_dig       <= '0;
            cnt         <= '0;
            stage_dig   <= '0;
            stage_err   <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            seg_m      <= seg;
            s_seg      <= seg_m;
            dig_m      <= dig;
            s_dig      <= dig_m;
            frame_done <= 1'b0;

            if (clr) begin
                // discards assembly progress; published outputs are left alone
                state     <= S_HUNT;
                l_seg     <= '0;
                l_dig     <= '0;
                cnt       <= '0;
                stage_dig <= '0;
                stage_err <= '0;
                seen      <= '0;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (s_onehot) begin
                            l_seg <= s_seg;
                            l_dig <= s_dig;
                            cnt   <= CW'(1);
                            state <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (sample_eq) begin
                            if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
                            if (capture) state <= S_HOLD;
                        end else if (s_onehot) begin
                            l_seg <= s_seg;
                            l_dig <= s_dig;
                            cnt   <= CW'(1);
                        end else begin
                            state <= S_HUNT;
                        end
                    end
                    S_HOLD: begin
                        if (!sample_eq) begin
                            if (s_onehot) begin
                                l_seg <= s_seg;
                                l_dig <= s_dig;
                                cnt   <= CW'(1);
                                state <= S_COUNT;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                    end
                    default: state <= S_HUNT;
                endcase

                if (capture) begin
                    stage_dig[cap_idx] <= cap_dec[3:0];
                    stage_err[cap_idx] <= cap_dec[4];
                end

                // a capture on the publish edge belongs to the next frame
                if (publish) begin
                    seen        <= capture ? cap_mask : '0;
                    digits      <= stage_dig;
                    digit_err   <= stage_err;
                    frame_valid <= 1'b1;
                    frame_done  <= 1'b1;
                end else if (capture) begin
                    seen <= seen | cap_mask;
                end
            end
        end
    end

endmodule
